// File: rtl/execute_controller_pkg.sv
// execute_controller_pkg: shared widths, opcode/aluop constants, instruction fields and FSM states.
package execute_controller_pkg;
    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;
    localparam int INSTR_W    = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam int OP_LSB   = 24;
    localparam int DST_LSB  = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 0;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;
endpackage

// File: rtl/execute_controller_reg_file_8x8.sv
// reg_file_8x8: 8x8 register file, two operand read ports, a debug read port, one synchronous write port.
module reg_file_8x8
    import execute_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    input  logic [REG_ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0]     rdata1_o,
    output logic [DATA_W-1:0]     rdata2_o,
    output logic [DATA_W-1:0]     dbg_rdata_o,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i
);
    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o    = mem_q[raddr1_i];
    assign rdata2_o    = mem_q[raddr2_i];
    assign dbg_rdata_o = mem_q[dbg_addr_i];
endmodule

// File: rtl/execute_controller.sv
// execute_controller: decodes one instruction per handshake, drives the external Alu and writes its result back.
module execute_controller
    import execute_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [DATA_W-1:0]     alu_data1,
    output logic [DATA_W-1:0]     alu_data2,
    output logic [2:0]            alu_select,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  done,
    output logic                  illegal,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0]     dbg_rdata
);
    state_e                state_q, state_d;
    logic [DATA_W-1:0]     data1_q, data1_d, data2_q, data2_d;
    logic [2:0]            sel_q, sel_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic                  ill_q, ill_d;
    logic                  accept, we;
    logic [DATA_W-1:0]     rs1, rs2;

    wire [7:0]        op  = instr[OP_LSB +: 8];
    wire [DATA_W-1:0] imm = instr[SRC2_LSB +: DATA_W];

    reg_file_8x8 u_rf (
        .clk         (clk),
        .reset       (reset),
        .raddr1_i    (instr[SRC1_LSB +: REG_ADDR_W]),
        .raddr2_i    (instr[SRC2_LSB +: REG_ADDR_W]),
        .dbg_addr_i  (dbg_addr),
        .rdata1_o    (rs1),
        .rdata2_o    (rs2),
        .dbg_rdata_o (dbg_rdata),
        .we_i        (we),
        .waddr_i     (dest_q),
        .wdata_i     (alu_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data1_q <= '0;
            data2_q <= '0;
            sel_q   <= ALU_FWD;
            dest_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
            sel_q   <= sel_d;
            dest_q  <= dest_d;
            ill_q   <= ill_d;
        end
    end

    always_comb begin
        instr_ready = (state_q == S_IDLE) && !reset;
        accept      = instr_valid && instr_ready;
        state_d     = state_q == S_IDLE ? (accept ? S_EXEC : S_IDLE) :
                      state_q == S_EXEC ? S_WB : S_IDLE;
        // Operand/aluop registers only load on accept so the Alu inputs stay stable until the next instruction.
        data1_d     = accept ? rs1 : data1_q;
        data2_d     = !accept ? data2_q :
                      op == OP_LOADI ? imm :
                      op == OP_SUB ? ~rs2 + DATA_W'(1) : rs2;
        sel_d       = !accept ? sel_q :
                      (op == OP_ADD || op == OP_SUB) ? ALU_ADD :
                      op == OP_AND ? ALU_AND :
                      op == OP_OR ? ALU_OR : ALU_FWD;
        dest_d      = accept ? instr[DST_LSB +: REG_ADDR_W] : dest_q;
        ill_d       = accept ? !(op inside {OP_LOADI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR}) : ill_q;
        we          = (state_q == S_EXEC) && !ill_q;
        done        = state_q == S_WB;
        illegal     = done && ill_q;
    end

    assign alu_data1  = data1_q;
    assign alu_data2  = data2_q;
    assign alu_select = sel_q;
endmodule

// File: tb/tb_execute_controller.sv
// tb_execute_controller: directed vectors into a scoreboard queue; a negedge monitor checks each retired instruction.
module tb_execute_controller;
    typedef struct {
        logic [31:0] ins;
        logic [2:0]  sel;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic        ill;
        logic [7:0]  wb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  alu_data1, alu_data2, alu_result;
    logic [2:0]  alu_select;
    logic        done, illegal;
    logic [2:0]  dbg_addr = '0;
    logic [7:0]  dbg_rdata;

    int   checks = 0, errors = 0, cyc = 0;
    vec_t exp_q[$];
    int   done_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        alu_result = alu_data2;
        if (alu_select == 3'b001) alu_result = 8'(alu_data1 + alu_data2);
        else if (alu_select == 3'b010) alu_result = alu_data1 & alu_data2;
        else if (alu_select == 3'b011) alu_result = alu_data1 | alu_data2;
    end

    execute_controller dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_data1   (alu_data1),
        .alu_data2   (alu_data2),
        .alu_select  (alu_select),
        .alu_result  (alu_result),
        .done        (done),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_rdata   (dbg_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        bit ok = 0;
        @(negedge clk);
        instr = v.ins;
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (instr_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 32'(ok), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (done) begin
            vec_t v;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                v = exp_q.pop_front();
                done_cyc.push_back(cyc);
                chk("illegal", 32'(illegal), 32'(v.ill));
                if (!v.ill) begin
                    chk("alu_select", 32'(alu_select), 32'(v.sel));
                    chk("alu_data1", 32'(alu_data1), 32'(v.d1));
                    chk("alu_data2", 32'(alu_data2), 32'(v.d2));
                end
                dbg_addr = v.ins[18:16];
                #1 chk("wb_reg", 32'(dbg_rdata), 32'(v.wb));
            end
        end
    end

    vec_t vecs[13] = '{
        '{32'h0001000A, 3'b000, 8'h00, 8'h0A, 1'b0, 8'h0A},
        '{32'h00020005, 3'b000, 8'h00, 8'h05, 1'b0, 8'h05},
        '{32'h02030102, 3'b001, 8'h0A, 8'h05, 1'b0, 8'h0F},
        '{32'h03040102, 3'b001, 8'h0A, 8'hFB, 1'b0, 8'h05},
        '{32'h04050102, 3'b010, 8'h0A, 8'h05, 1'b0, 8'h00},
        '{32'h05060102, 3'b011, 8'h0A, 8'h05, 1'b0, 8'h0F},
        '{32'h000100FF, 3'b000, 8'h00, 8'hFF, 1'b0, 8'hFF},
        '{32'h00020001, 3'b000, 8'h00, 8'h01, 1'b0, 8'h01},
        '{32'h02070102, 3'b001, 8'hFF, 8'h01, 1'b0, 8'h00},
        '{32'h01000007, 3'b000, 8'h00, 8'h00, 1'b0, 8'h00},
        '{32'h07030102, 3'b000, 8'hFF, 8'h00, 1'b1, 8'h0F},
        '{32'h0001000A, 3'b000, 8'h00, 8'h0A, 1'b0, 8'h0A},
        '{32'h00020005, 3'b000, 8'h00, 8'h05, 1'b0, 8'h05}
    };

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] pat = 6'b001001;
        vec_t held = '{32'h02030102, 3'b001, 8'h0A, 8'h05, 1'b0, 8'h0F};
        repeat (3) @(posedge clk);
        #1 chk("ready_in_reset", 32'(instr_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_alu", {21'b0, alu_select, alu_data1, alu_data2}, 32'd0);

        foreach (vecs[k]) issue(vecs[k]);
        repeat (4) @(negedge clk);

        done_cyc.delete();
        instr = held.ins;
        instr_valid = 1'b1;
        exp_q.push_back(held);
        exp_q.push_back(held);
        for (int i = 0; i < 6; i++) begin
            chk("ready_hold", 32'(instr_ready), 32'(pat[i]));
            @(negedge clk);
        end
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("hold_done_count", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2) chk("hold_done_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd3);

        instr = 32'h02030102;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(instr_ready), 32'd1);
        chk("post_rst_alu", {21'b0, alu_select, alu_data1, alu_data2}, 32'd0);
        repeat (4) @(negedge clk);
        issue('{32'h02030102, 3'b001, 8'h00, 8'h00, 1'b0, 8'h00});
        issue('{32'h05050607, 3'b011, 8'h00, 8'h00, 1'b0, 8'h00});
        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
